// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-mode encodings, default widths
// and the buffer entry layout at default widths.
package wb_pkg;

    localparam logic [1:0] LD_WORD   = 2'b00;
    localparam logic [1:0] LD_BYTE_U = 2'b01;
    localparam logic [1:0] LD_BYTE_S = 2'b10;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 3;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_DATA_W-1:0] result;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Result select for a retiring instruction: ALU result, or load data with
// optional byte zero/sign extension.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic              sel_mem,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = alu;
        if (sel_mem) begin
            case (mode)
                LD_BYTE_U: result = DATA_W'(data[7:0]);
                LD_BYTE_S: result = DATA_W'($signed(data[7:0]));
                default:   result = data;
            endcase
        end
    end

endmodule

// File: rtl/writeback_pipe.sv
// Writeback stage: OUT + SKID buffer feeding the register-file write port, with a
// retire counter. Define WB_FWD_EN to add the operand-bypass outputs.
module writeback_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic              in_sel_mem,
    input  logic [1:0]        in_ld_mode,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] ans_wb,
    output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] result;
    } entry_t;

    entry_t            out_q, skid_q, out_n, skid_n, new_e;
    logic              rdy_q;
    logic              accept, retire;
    logic [DATA_W-1:0] aligned;

    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .alu     (in_alu),
        .data    (in_mem),
        .mode    (in_ld_mode),
        .sel_mem (in_sel_mem),
        .result  (aligned)
    );

    always_comb begin
        new_e.valid  = 1'b1;
        new_e.wr     = in_we & (in_rd != '0);
        new_e.rd     = in_rd;
        new_e.result = aligned;
    end

    assign accept = in_valid & rdy_q;
    assign retire = out_q.valid & (~out_q.wr | rf_ready);

    // Retire frees OUT first, SKID then advances, and a new entry fills the
    // first free slot: this keeps order without a separate pointer.
    always_comb begin
        out_n  = out_q;
        skid_n = skid_q;
        if (retire) begin
            out_n.valid = 1'b0;
            if (skid_q.valid) begin
                out_n        = skid_q;
                skid_n.valid = 1'b0;
            end
        end
        if (accept) begin
            if (!out_n.valid) out_n  = new_e;
            else              skid_n = new_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q      <= '0;
            skid_q     <= '0;
            rdy_q      <= 1'b1;
            ans_wb     <= '0;
            retire_cnt <= '0;
        end else begin
            out_q  <= out_n;
            skid_q <= skid_n;
            rdy_q  <= ~skid_n.valid;
            if (retire) begin
                ans_wb     <= out_q.result;
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready = rdy_q;
    // Gated by reset so a stalled entry is never strobed while reset is held.
    assign rf_we    = reset & out_q.valid & out_q.wr;
    assign rf_addr  = out_q.rd;
    assign rf_wdata = out_q.result;

`ifdef WB_FWD_EN
    logic skid_fwd;
    assign skid_fwd  = skid_q.valid & skid_q.wr;
    assign fwd_valid = reset & (skid_fwd | (out_q.valid & out_q.wr));
    assign fwd_addr  = skid_fwd ? skid_q.rd     : out_q.rd;
    assign fwd_data  = skid_fwd ? skid_q.result : out_q.result;
`endif

endmodule

// File: tb/tb_writeback_pipe.sv
// Bench for writeback_pipe: table of single-entry loads plus directed backpressure,
// r0, reset-mid-stall and counter-wrap sequences, with a write scoreboard.
module tb_writeback_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_alu;
    logic [15:0] in_mem;
    logic        in_sel_mem;
    logic [1:0]  in_ld_mode;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        rf_ready;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic [15:0] ans_wb;
    logic [3:0]  retire_cnt;

    int passed = 0;
    int total  = 0;
    int exp_cnt = 0;
    logic [18:0] sb[$];

    writeback_pipe #(.DATA_W(16), .REG_AW(3), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu     (in_alu),
        .in_mem     (in_mem),
        .in_sel_mem (in_sel_mem),
        .in_ld_mode (in_ld_mode),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .rf_ready   (rf_ready),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .ans_wb     (ans_wb),
        .retire_cnt (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] alu;
        logic [15:0] mem;
        logic        sel;
        logic [1:0]  mode;
        logic [2:0]  rd;
        logic        we;
        logic [15:0] exp;
        logic        strobe;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] alu, input logic [15:0] mem, input logic sel,
                         input logic [1:0] mode, input logic [2:0] rd, input logic we);
        in_valid   = 1'b1;
        in_alu     = alu;
        in_mem     = mem;
        in_sel_mem = sel;
        in_ld_mode = mode;
        in_rd      = rd;
        in_we      = we;
    endtask

    // A write commits on the coming edge whenever rf_we & rf_ready are seen here.
    always @(negedge clk) begin
        if (reset === 1'b1 && rf_we === 1'b1 && rf_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected_write: got addr %0h data %0h expected none", rf_addr, rf_wdata);
            end else begin
                check("sb_write", {13'b0, rf_addr, rf_wdata}, {13'b0, sb.pop_front()});
            end
        end
    end

    initial begin
        vecs[0] = '{16'h0000, 16'h12F0, 1'b1, 2'b10, 3'd3, 1'b1, 16'hFFF0, 1'b1};
        vecs[1] = '{16'h0000, 16'h12F0, 1'b1, 2'b01, 3'd3, 1'b1, 16'h00F0, 1'b1};
        vecs[2] = '{16'h0000, 16'h1280, 1'b1, 2'b00, 3'd5, 1'b1, 16'h1280, 1'b1};
        vecs[3] = '{16'h0000, 16'h3480, 1'b1, 2'b11, 3'd7, 1'b1, 16'h3480, 1'b1};
        vecs[4] = '{16'h0000, 16'hAB7F, 1'b1, 2'b10, 3'd1, 1'b1, 16'h007F, 1'b1};
        vecs[5] = '{16'hA5A5, 16'hFFFF, 1'b0, 2'b10, 3'd2, 1'b1, 16'hA5A5, 1'b1};
        vecs[6] = '{16'hBEEF, 16'h0000, 1'b0, 2'b00, 3'd0, 1'b1, 16'hBEEF, 1'b0};
        vecs[7] = '{16'h1234, 16'h0000, 1'b0, 2'b00, 3'd4, 1'b0, 16'h1234, 1'b0};

        // Reset held two cycles with a valid entry offered.
        reset    = 1'b0;
        rf_ready = 1'b1;
        drive(16'h5555, 16'h6666, 1'b0, 2'b00, 3'd3, 1'b1);
        step();
        step();
        check("rst_rf_we", rf_we, 0);
        check("rst_ans_wb", ans_wb, 0);
        check("rst_retire_cnt", retire_cnt, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_rf_addr", rf_addr, 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_rf_we_after", rf_we, 0);

        // Single entries through an empty stage.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].alu, vecs[i].mem, vecs[i].sel, vecs[i].mode, vecs[i].rd, vecs[i].we);
            if (vecs[i].strobe) sb.push_back({vecs[i].rd, vecs[i].exp});
            check("vec_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            check("vec_rf_we", rf_we, vecs[i].strobe);
            if (vecs[i].strobe) begin
                check("vec_rf_wdata", rf_wdata, vecs[i].exp);
                check("vec_rf_addr", rf_addr, vecs[i].rd);
            end
            step();
            exp_cnt++;
            check("vec_ans_wb", ans_wb, vecs[i].exp);
            check("vec_retire_cnt", retire_cnt, exp_cnt % 16);
            check("vec_rf_we_idle", rf_we, 0);
        end

        // Backpressure: three back-to-back entries against a stalled register file.
        rf_ready = 1'b0;
        drive(16'h0001, 16'h0000, 1'b0, 2'b00, 3'd1, 1'b1);
        sb.push_back({3'd1, 16'h0001});
        step();
        check("bp_rf_we", rf_we, 1);
        check("bp_rf_wdata_1", rf_wdata, 16'h0001);
        check("bp_in_ready_1", in_ready, 1);
        drive(16'h0002, 16'h0000, 1'b0, 2'b00, 3'd2, 1'b1);
        sb.push_back({3'd2, 16'h0002});
        step();
        check("bp_in_ready_2", in_ready, 0);
        check("bp_hold_data_a", rf_wdata, 16'h0001);
        drive(16'h0003, 16'h0000, 1'b0, 2'b00, 3'd3, 1'b1);
        sb.push_back({3'd3, 16'h0003});
        step();
        check("bp_in_ready_3", in_ready, 0);
        check("bp_hold_data_b", rf_wdata, 16'h0001);
        step();
        check("bp_hold_addr", rf_addr, 1);
        check("bp_hold_data_c", rf_wdata, 16'h0001);
        check("bp_stall_cnt", retire_cnt, exp_cnt % 16);
        rf_ready = 1'b1;
        step();
        exp_cnt++;
        check("bp_out_2", rf_wdata, 16'h0002);
        check("bp_ans_1", ans_wb, 16'h0001);
        check("bp_in_ready_reopen", in_ready, 1);
        step();
        exp_cnt++;
        in_valid = 1'b0;
        check("bp_out_3", rf_wdata, 16'h0003);
        check("bp_ans_2", ans_wb, 16'h0002);
        step();
        exp_cnt++;
        check("bp_ans_3", ans_wb, 16'h0003);
        check("bp_rf_we_done", rf_we, 0);
        check("bp_retire_cnt", retire_cnt, exp_cnt % 16);

        // r0 destination retires without a strobe even while stalled.
        rf_ready = 1'b0;
        drive(16'hBEEF, 16'h0000, 1'b0, 2'b00, 3'd0, 1'b1);
        step();
        in_valid = 1'b0;
        check("r0_rf_we", rf_we, 0);
        step();
        exp_cnt++;
        check("r0_ans_wb", ans_wb, 16'hBEEF);
        check("r0_retire_cnt", retire_cnt, exp_cnt % 16);
        check("r0_rf_we_after", rf_we, 0);

        // Reset while both slots are full: entries are dropped.
        drive(16'h6666, 16'h0000, 1'b0, 2'b00, 3'd6, 1'b1);
        step();
        drive(16'h7777, 16'h0000, 1'b0, 2'b00, 3'd7, 1'b1);
        step();
        in_valid = 1'b0;
        check("mid_full_in_ready", in_ready, 0);
        reset = 1'b0;
        step();
        reset   = 1'b1;
        exp_cnt = 0;
        check("mid_rf_we", rf_we, 0);
        check("mid_retire_cnt", retire_cnt, 0);
        step();
        check("mid_in_ready", in_ready, 1);
        rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_write", rf_we, 0);
        end
        check("mid_cnt_after", retire_cnt, 0);
        check("mid_ans_after", ans_wb, 0);

        // 17 back-to-back retirements wrap the 4-bit counter to 1.
        for (int k = 0; k < 17; k++) begin
            drive(16'h0100 + 16'(k), 16'h0000, 1'b0, 2'b00, 3'((k % 7) + 1), 1'b1);
            sb.push_back({3'((k % 7) + 1), 16'h0100 + 16'(k)});
            check("wrap_in_ready", in_ready, 1);
            step();
            check("wrap_stream_data", rf_wdata, 16'h0100 + 16'(k));
        end
        in_valid = 1'b0;
        step();
        exp_cnt += 17;
        check("wrap_retire_cnt", retire_cnt, exp_cnt % 16);
        check("wrap_ans_wb", ans_wb, 16'h0110);

        step();
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
